// File: rtl/fetch_window.sv
// Compacting instruction buffer: accepts one instruction per cycle, exposes the
// oldest FETCH_WIDTH entries as a window, and squeezes out consumed slots.
module fetch_window #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [23:0]                   in_instr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [FETCH_WIDTH*24-1:0]     instr_out,
    output logic [FETCH_WIDTH-1:0]        instr_valid,
    input  logic [FETCH_WIDTH-1:0]        instr_used,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [23:0]   mem_reg  [DEPTH];
    logic [23:0]   mem_next [DEPTH];
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW-1:0] shift_cnt;
    logic [CW-1:0] dest;
    logic [CW-1:0] k;
    logic [DEPTH-1:0] rm_wide;
    logic          push;

    assign in_ready = (count_reg != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign count    = count_reg;

    // Removal mask widened to the full buffer; slots past the window never drop.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rm
        if (gi < FETCH_WIDTH) begin : g_win
            assign rm_wide[gi] = instr_used[gi] & instr_valid[gi];
        end else begin : g_tail
            assign rm_wide[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_out
        assign instr_valid[gi]           = (CW'(gi) < count_reg);
        assign instr_out[24*gi +: 24]    = instr_valid[gi] ? mem_reg[gi] : 24'h000000;
    end

    // Each surviving entry moves down by the number of removed entries ahead of it.
    always_comb begin
        mem_next  = mem_reg;
        shift_cnt = '0;
        dest      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (rm_wide[j]) begin
                shift_cnt = shift_cnt + 1'b1;
            end else begin
                dest = CW'(j) - shift_cnt;
                mem_next[dest[AW-1:0]] = mem_reg[j];
            end
        end
        k = count_reg - shift_cnt;
        if (push) begin
            mem_next[k[AW-1:0]] = in_instr;
        end
        count_next = k + CW'(push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_reg[j] <= '0;
            end
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            for (int j = 0; j < DEPTH; j++) begin
                mem_reg[j] <= mem_next[j];
            end
        end
    end
endmodule

// File: tb/tb_fetch_window.sv
// Directed bench for fetch_window: push, holes, push+remove, full, flush, reset.
module tb_fetch_window;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [95:0] instr_out;
    logic [3:0]  instr_valid;
    logic [3:0]  instr_used;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [23:0] A = 24'h100001, B = 24'h200002, C = 24'h300003;
    localparam logic [23:0] D = 24'h400004, E = 24'h500005, F = 24'h600006;
    localparam logic [23:0] G = 24'h700007, X = 24'hABCDEF, Y = 24'h0000AA;
    localparam logic [23:0] Z = 24'h0000ZZ === 24'h0 ? 24'h0 : 24'h123456;
    localparam logic [23:0] P = 24'hC0FFEE;

    fetch_window #(.FETCH_WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_used(instr_used), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [23:0] v);
        in_instr = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_instr = '0; in_valid = 1'b0; flush = 1'b0; instr_used = '0;
        step(); step();
        check("rst_valid", 96'(instr_valid), 96'h0);
        check("rst_ready", 96'(in_ready), 96'h1);
        check("rst_count", 96'(count), 96'h0);
        check("rst_out", instr_out, 96'h0);
        rst = 1'b0;

        // Reset/push
        push_one(A); push_one(B); push_one(C);
        check("push_valid", 96'(instr_valid), 96'h7);
        check("push_out", instr_out, {24'h0, C, B, A});
        check("push_count", 96'(count), 96'd3);

        // Holes: A,B,C,D,E,F with used=0101 removes A and C
        push_one(D); push_one(E); push_one(F);
        check("six_count", 96'(count), 96'd6);
        instr_used = 4'b0101; step(); instr_used = '0;
        check("holes_out", instr_out, {F, E, D, B});
        check("holes_count", 96'(count), 96'd4);
        check("holes_valid", 96'(instr_valid), 96'hF);

        // Drop E,F to leave B,D, then remove B while pushing G
        instr_used = 4'b1100; step(); instr_used = '0;
        check("trim_count", 96'(count), 96'd2);
        instr_used = 4'b0001; in_instr = G; in_valid = 1'b1; step();
        instr_used = '0; in_valid = 1'b0;
        check("pushrm_out", instr_out, {24'h0, 24'h0, G, D});
        check("pushrm_count", 96'(count), 96'd2);

        // Full: D,G + six more entries
        for (int i = 1; i <= 6; i++) push_one(24'h800000 + 24'(i));
        check("full_count", 96'(count), 96'd8);
        check("full_ready", 96'(in_ready), 96'h0);
        in_instr = X; in_valid = 1'b1; instr_used = 4'b0001; step();
        instr_used = '0;
        check("full_refuse_count", 96'(count), 96'd7);
        check("full_refuse_out", instr_out, {24'h800003, 24'h800002, 24'h800001, G});
        check("full_ready_again", 96'(in_ready), 96'h1);
        step(); in_valid = 1'b0;
        check("full_accept_count", 96'(count), 96'd8);
        instr_used = 4'b1111; step(); instr_used = '0;
        check("x_visible", instr_out, {X, 24'h800006, 24'h800005, 24'h800004});
        check("drain4_count", 96'(count), 96'd4);

        // Flush with simultaneous push and used
        push_one(Y);
        check("pre_flush_count", 96'(count), 96'd5);
        flush = 1'b1; in_valid = 1'b1; in_instr = Z; instr_used = 4'b1111; step();
        flush = 1'b0; in_valid = 1'b0; instr_used = '0;
        check("flush_count", 96'(count), 96'd0);
        check("flush_valid", 96'(instr_valid), 96'h0);
        check("flush_out", instr_out, 96'h0);

        // Used bits on invalid slots are ignored
        push_one(P);
        instr_used = 4'b1110; step(); instr_used = '0;
        check("invused_count", 96'(count), 96'd1);
        check("invused_out", instr_out, {24'h0, 24'h0, 24'h0, P});

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("arst_count", 96'(count), 96'd0);
        check("arst_valid", 96'(instr_valid), 96'h0);
        check("arst_out", instr_out, 96'h0);
        check("arst_ready", 96'(in_ready), 96'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fetch_window.md
# fetch_window

Compacting instruction buffer that sits directly upstream of the type sorter. It accepts one 24-bit instruction per cycle from fetch and presents its oldest FETCH_WIDTH entries as a parallel window with per-slot valid bits. Each cycle it accepts back a per-slot used mask, which may have holes, and removes exactly those entries. Survivors stay in program order at the front of the buffer.

## Interface
- FETCH_WIDTH, 4, number of window slots presented downstream
- DEPTH, 8, total buffer entries; must be ≥ FETCH_WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_instr  in  24  instruction from fetch
- in_valid  in  1  in_instr is valid this cycle
- in_ready  out  1  buffer can accept in_instr this cycle
- flush  in  1  discard all buffered entries, e.g. on redirect
- instr_out  out  FETCH_WIDTH*24  window; slot i is bits [24i+23:24i], slot 0 is oldest
- instr_valid  out  FETCH_WIDTH  slot i holds a live instruction
- instr_used  in  FETCH_WIDTH  downstream consumed slot i this cycle
- count  out  $clog2(DEPTH+1)  number of live entries

## Operation
- Storage is DEPTH entries, entry 0 oldest, kept compacted. Live entries always occupy positions 0..count-1.
- instr_valid[i] = (i < count).
- instr_out slot i = entry i when valid, else 24'h000000.
- Effective removal mask: rm = instr_used & instr_valid. Used bits on invalid slots are ignored.
- Per cycle, when flush=0:
  - Survivors are the window entries with rm=0, in original order, followed by entries FETCH_WIDTH..count-1.
  - Survivors are written to positions 0..k-1, where k = count − popcount(rm).
  - If in_valid & in_ready, in_instr is written at position k.
  - count_next = k + (in_valid & in_ready).
- in_ready = (count < DEPTH). It depends on registered state only. There is no combinational path from instr_used or in_valid.
- A same-cycle push and removal when count == DEPTH−1 is legal. A push is refused when count == DEPTH, even if removals occur that cycle.
- flush=1: count_next = 0 and all instr_valid go low next cycle. in_instr pushed in the same cycle is dropped. instr_used is ignored. Flush has priority over everything else.
- Positions at or beyond count_next hold don't-care contents internally. They are never visible on the outputs because of masking.
- No combinational path from in_instr/in_valid to instr_out/instr_valid. A pushed instruction is visible at the earliest on the next cycle.

## Timing
- Reset (async assert): count=0, instr_valid=0, instr_out=0, in_ready=1. Storage is cleared to zero.
- Reset is released synchronously to clk by the surrounding logic. The first push is accepted on the first edge after deassertion.
- Latency from fetch to window: 1 cycle when the new entry lands at position < FETCH_WIDTH.
- Removal latency: used slots disappear and survivors shift on the same edge. The next cycle's window already reflects the compaction.
- Throughput: 1 push/cycle sustained while count < DEPTH. Up to FETCH_WIDTH removals per cycle.
- Reset mid-operation clears everything immediately, regardless of flush, in_valid or instr_used.

## Test plan
- **Reset/push.** Assert rst, release, push A=0x100001, B=0x200002, C=0x300003 on consecutive cycles with no used.
  - After rst: instr_valid=0000, in_ready=1.
  - After pushes: instr_valid=0111, slot0=A, slot1=B, slot2=C, count=3.
- **Holes.** Window A,B,C,D (count=6, E,F behind), instr_used=0101.
  - Next cycle: slots = B,D,E,F; count=4; instr_valid=1111.
- **Simultaneous push/remove.** count=2 (A,B), used=0001, push G.
  - Next cycle: slots = B,G; count=2.
- **Full.** Fill to DEPTH=8: in_ready=0.
  - Assert in_valid with X plus used=0001: X is not accepted; count=7.
  - Following cycle: in_ready=1; X is accepted with count 7→8.
- **Flush.** count=5, flush=1 with in_valid=1 and used=1111.
  - Next cycle: count=0, instr_valid=0000, instr_out=0, pushed instruction absent.
- **Invalid-used / async reset.** count=1, used=1110: no change, count=1.
  - Assert rst mid-cycle: outputs clear without waiting for a clock edge.
